pu_mac_pipe: RTL and testbench

Parametrised, fully pipelined processing unit for the neural datapath. It computes the unsigned dot product of N_IN inputs and N_IN weights. It can accumulate that dot product over a multi-beat frame and compares the result against a runtime threshold. It replaces the fixed 4-input processing units: same multiply, register, adder-tree structure, plus valid/ready flow control, frame accumulation, saturation and a fire flag.

---
 rtl/pu_mac_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_pu_mac_pipe.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_mac_pipe.sv
// pu_mac_pipe: three-stage unsigned multiply / adder-tree / accumulate unit.
// S1 registers the per-channel products, S2 reduces them through a binary
// adder tree, S3 accumulates tree sums over a frame with saturation and
// presents the frame result together with overflow and threshold-fire flags.
// A single advance signal stalls the whole pipeline when the result register
// is full and downstream is not accepting.
module pu_mac_pipe #(
    parameter int DATA_W = 5,
    parameter int N_IN   = 4,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic                     in_mode,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_IN*DATA_W-1:0]   in_weight,
    input  logic [ACC_W-1:0]         thr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     out_overflow,
    output logic                     out_fire
);

    // ACC_W is expected to be at least SUM_W so a single beat never saturates.
    localparam int PROD_W = 2 * DATA_W;
    localparam int LOG_N  = $clog2(N_IN);
    localparam int SUM_W  = PROD_W + LOG_N;
    localparam int N_NODE = 2 * N_IN - 1;

    // Accumulator FSM encoding.
    localparam logic [0:0] ST_FRESH = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    // Saturating add: bit ACC_W is the saturation flag, low ACC_W bits the
    // clamped result.
    function automatic logic [ACC_W:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [SUM_W-1:0] b
    );
        logic [ACC_W:0] raw;
        raw = {1'b0, a} + {{(ACC_W + 1 - SUM_W){1'b0}}, b};
        if (raw[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = raw;
        end
    endfunction

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic advance_s;

    // Whole pipeline moves only when the result slot is free or being drained.
    always_comb begin
        advance_s = (~out_valid) | out_ready;
    end

    assign in_ready = advance_s;

    // ------------------------------------------------------------------
    // Input-side frame tracking (mode latch)
    // ------------------------------------------------------------------
    // Only accumulate-mode frames can span several beats, so while a frame is
    // open the effective mode is always 1 and in_mode is ignored.
    logic in_frame_r;
    logic beat_mode_s;

    // Effective mode of the beat currently on the inputs.
    always_comb begin
        if (in_frame_r) begin
            beat_mode_s = 1'b1;
        end else begin
            beat_mode_s = in_mode;
        end
    end

    // Open a frame on a non-last accumulate beat, close it on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame_r <= 1'b0;
        end else if (in_valid && advance_s) begin
            in_frame_r <= beat_mode_s & ~in_last;
        end
    end

    // ------------------------------------------------------------------
    // Stage S1: products
    // ------------------------------------------------------------------
    logic              s1_valid_r;
    logic              s1_last_r;
    logic              s1_mode_r;
    logic [PROD_W-1:0] s1_prod_r [N_IN];

    // Register per-channel products with the beat's control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_mode_r  <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                s1_prod_r[i] <= {PROD_W{1'b0}};
            end
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_last_r <= in_last;
                s1_mode_r <= beat_mode_s;
                for (int i = 0; i < N_IN; i++) begin
                    s1_prod_r[i] <= PROD_W'(in_data[i*DATA_W +: DATA_W]) *
                                    PROD_W'(in_weight[i*DATA_W +: DATA_W]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage S2: binary adder tree
    // ------------------------------------------------------------------
    // Heap layout: leaves at [N_IN-1 .. 2*N_IN-2], node k sums 2k+1 and 2k+2.
    // Every node is carried at SUM_W; a level-d node never needs more than
    // PROD_W+d bits, so the upper bits of the shallow nodes stay zero.
    logic [SUM_W-1:0] tree_s [N_NODE];

    // Reduce the S1 products to a single sum.
    always_comb begin
        for (int k = 0; k < N_NODE; k++) begin
            tree_s[k] = {SUM_W{1'b0}};
        end
        for (int k = 0; k < N_IN; k++) begin
            tree_s[N_IN - 1 + k] = SUM_W'(s1_prod_r[k]);
        end
        for (int k = N_IN - 2; k >= 0; k--) begin
            tree_s[k] = tree_s[2*k + 1] + tree_s[2*k + 2];
        end
    end

    logic             s2_valid_r;
    logic             s2_last_r;
    logic             s2_mode_r;
    logic [SUM_W-1:0] s2_sum_r;

    // Register the tree sum with the beat's control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_mode_r  <= 1'b0;
            s2_sum_r   <= {SUM_W{1'b0}};
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_last_r <= s1_last_r;
                s2_mode_r <= s1_mode_r;
                s2_sum_r  <= tree_s[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage S3: accumulator FSM and result register
    // ------------------------------------------------------------------
    logic [0:0]       state_r;
    logic [ACC_W-1:0] acc_r;
    logic             ovf_r;

    logic [ACC_W-1:0] base_acc_s;
    logic             base_ovf_s;
    logic [ACC_W:0]   add_s;
    logic [ACC_W-1:0] new_acc_s;
    logic             new_ovf_s;
    logic             new_fire_s;
    logic             frame_end_s;

    // A fresh frame starts from zero with a clear overflow flag; otherwise
    // continue from the running accumulator and sticky flag.
    always_comb begin
        base_acc_s = {ACC_W{1'b0}};
        base_ovf_s = 1'b0;
        case (state_r)
            ST_FRESH: begin
                base_acc_s = {ACC_W{1'b0}};
                base_ovf_s = 1'b0;
            end
            ST_ACCUM: begin
                base_acc_s = acc_r;
                base_ovf_s = ovf_r;
            end
            default: begin
                base_acc_s = {ACC_W{1'b0}};
                base_ovf_s = 1'b0;
            end
        endcase
        add_s       = sat_add(base_acc_s, s2_sum_r);
        new_acc_s   = add_s[ACC_W-1:0];
        new_ovf_s   = base_ovf_s | add_s[ACC_W];
        new_fire_s  = (new_acc_s >= thr);
        frame_end_s = s2_last_r | ~s2_mode_r;
    end

    // Accumulate valid S2 beats; on frame end load the result and re-arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FRESH;
            acc_r        <= {ACC_W{1'b0}};
            ovf_r        <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= {ACC_W{1'b0}};
            out_overflow <= 1'b0;
            out_fire     <= 1'b0;
        end else if (advance_s) begin
            if (s2_valid_r) begin
                acc_r <= new_acc_s;
                ovf_r <= new_ovf_s;
                if (frame_end_s) begin
                    state_r      <= ST_FRESH;
                    out_valid    <= 1'b1;
                    out_sum      <= new_acc_s;
                    out_overflow <= new_ovf_s;
                    out_fire     <= new_fire_s;
                end else begin
                    state_r   <= ST_ACCUM;
                    out_valid <= 1'b0;
                end
            end else begin
                // Bubble: accumulator untouched, any held result was consumed.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pu_mac_pipe.sv
// Testbench for pu_mac_pipe: two instances (ACC_W = 16 and ACC_W = 12) share
// the same stimulus; a frame-level scoreboard predicts every result.
module tb_pu_mac_pipe;

    localparam int DATA_W = 5;
    localparam int N_IN   = 4;
    localparam int VW     = DATA_W * N_IN;
    localparam int MAX_A  = 65535;
    localparam int MAX_B  = 4095;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic          in_mode;
    logic [VW-1:0] in_data;
    logic [VW-1:0] in_weight;
    logic [15:0]   thr;
    logic          out_ready;
    logic [11:0]   thr_b;

    logic          in_ready_a, out_valid_a, ovf_a, fire_a;
    logic [15:0]   out_sum_a;
    logic          in_ready_b, out_valid_b, ovf_b, fire_b;
    logic [11:0]   out_sum_b;

    assign thr_b = thr[11:0];

    pu_mac_pipe #(.DATA_W(DATA_W), .N_IN(N_IN), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_last(in_last), .in_mode(in_mode), .in_data(in_data),
        .in_weight(in_weight), .thr(thr), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(out_sum_a), .out_overflow(ovf_a),
        .out_fire(fire_a)
    );

    pu_mac_pipe #(.DATA_W(DATA_W), .N_IN(N_IN), .ACC_W(12)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_last(in_last), .in_mode(in_mode), .in_data(in_data),
        .in_weight(in_weight), .thr(thr_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_overflow(ovf_b),
        .out_fire(fire_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Single comparison point.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int sa; int oa; int sb; int ob; int th;
    } exp_t;

    exp_t exp_q[$];
    int   m_open = 0;
    int   m_acc_a = 0, m_acc_b = 0, m_ovf_a = 0, m_ovf_b = 0;
    int   last_acc_cyc = 0, out_cyc = 0, out_cnt = 0;
    int   fresh = 1;
    int   last_sum_a = 0, last_sum_b = 0, last_ovf_a = 0, last_ovf_b = 0, last_fire_a = 0;
    logic rdy_rand = 1'b0;

    function automatic int dot(input logic [VW-1:0] d, input logic [VW-1:0] w);
        int s = 0;
        for (int i = 0; i < N_IN; i++) begin
            s += int'(d[i*DATA_W +: DATA_W]) * int'(w[i*DATA_W +: DATA_W]);
        end
        return s;
    endfunction

    function automatic logic [VW-1:0] rep(input logic [4:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [VW-1:0] vec(input logic [4:0] c0, input logic [4:0] c1,
                                          input logic [4:0] c2, input logic [4:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic model_beat();
        int d;
        int md;
        exp_t e;
        d  = dot(in_data, in_weight);
        md = (m_open != 0) ? 1 : int'(in_mode);
        if (m_open == 0) begin
            m_acc_a = 0; m_acc_b = 0; m_ovf_a = 0; m_ovf_b = 0;
        end
        if (m_acc_a + d > MAX_A) begin m_acc_a = MAX_A; m_ovf_a = 1; end
        else m_acc_a = m_acc_a + d;
        if (m_acc_b + d > MAX_B) begin m_acc_b = MAX_B; m_ovf_b = 1; end
        else m_acc_b = m_acc_b + d;
        last_acc_cyc = cyc;
        if (md == 0 || in_last) begin
            e.sa = m_acc_a; e.oa = m_ovf_a; e.sb = m_acc_b; e.ob = m_ovf_b;
            e.th = int'(thr);
            exp_q.push_back(e);
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: sample mid-cycle, compare results against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            m_open = 0;
            fresh  = 1;
        end else begin
            if (out_valid_a) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    check_val("sum_a",  32'(out_sum_a), 32'(e.sa));
                    check_val("ovf_a",  32'(ovf_a),     32'(e.oa));
                    check_val("fire_a", 32'(fire_a),    32'(e.sa >= e.th));
                    check_val("valid_b", 32'(out_valid_b), 32'd1);
                    check_val("sum_b",  32'(out_sum_b), 32'(e.sb));
                    check_val("ovf_b",  32'(ovf_b),     32'(e.ob));
                    check_val("fire_b", 32'(fire_b),    32'(e.sb >= (e.th & 4095)));
                    if (fresh != 0) begin
                        out_cyc = cyc;
                        fresh   = 0;
                    end
                    if (out_ready) begin
                        last_sum_a  = int'(out_sum_a);
                        last_sum_b  = int'(out_sum_b);
                        last_ovf_a  = int'(ovf_a);
                        last_ovf_b  = int'(ovf_b);
                        last_fire_a = int'(fire_a);
                        void'(exp_q.pop_front());
                        fresh = 1;
                        out_cnt++;
                    end
                end
            end
            if (in_valid && in_ready_a) model_beat();
        end
    end

    // Random backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic send_beat(input logic [VW-1:0] d, input logic [VW-1:0] w,
                             input logic mode, input logic last);
        logic took;
        int   guard;
        in_valid = 1'b1; in_data = d; in_weight = w; in_mode = mode; in_last = last;
        took = 1'b0;
        guard = 0;
        while (!took && guard < 200) begin
            @(negedge clk);
            took = in_ready_a;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!took) check_val("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(input int target);
        int g = 0;
        while (out_cnt < target && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (out_cnt < target) check_val("out_timeout", 32'(out_cnt), 32'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid_a"}, 32'(out_valid_a), 32'd0);
        check_val({tag, "_sum_a"},   32'(out_sum_a),   32'd0);
        check_val({tag, "_ovf_a"},   32'(ovf_a),       32'd0);
        check_val({tag, "_fire_a"},  32'(fire_a),      32'd0);
        check_val({tag, "_ready_a"}, 32'(in_ready_a),  32'd1);
        check_val({tag, "_valid_b"}, 32'(out_valid_b), 32'd0);
        check_val({tag, "_sum_b"},   32'(out_sum_b),   32'd0);
        check_val({tag, "_ready_b"}, 32'(in_ready_b),  32'd1);
    endtask

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int g;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0;
        in_data = '0; in_weight = '0; thr = 16'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;

        // Mode 0 single beat, all 31: latency and full-scale sum.
        thr = 16'd3844;
        n = out_cnt;
        send_beat(rep(5'd31), rep(5'd31), 1'b0, 1'b0);
        wait_out(n + 1);
        check_val("t1_sum",     32'(last_sum_a), 32'd3844);
        check_val("t1_ovf",     32'(last_ovf_a), 32'd0);
        check_val("t1_fire",    32'(last_fire_a), 32'd1);
        check_val("t1_latency", 32'(out_cyc - last_acc_cyc), 32'd3);

        // Mode 1, three beats of sum 10, thr 30 then 31 (mode toggles mid-frame ignored).
        thr = 16'd30;
        n = out_cnt;
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b1, 1'b0);
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b1, 1'b0);
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b1, 1'b1);
        wait_out(n + 1);
        idle(2);
        check_val("t2_count", 32'(out_cnt - n), 32'd1);
        check_val("t2_sum",   32'(last_sum_a),  32'd30);
        check_val("t2_fire",  32'(last_fire_a), 32'd1);
        thr = 16'd31;
        n = out_cnt;
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b1, 1'b0);
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b0, 1'b0);
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b0, 1'b1);
        wait_out(n + 1);
        check_val("t2b_sum",  32'(last_sum_a),  32'd30);
        check_val("t2b_fire", 32'(last_fire_a), 32'd0);

        // Stall: four back-to-back mode 0 beats, out_ready low 5 cycles.
        thr = 16'd0;
        n = out_cnt;
        fork
            begin
                send_beat(rep(5'd1), rep(5'd1), 1'b0, 1'b0);
                send_beat(rep(5'd2), rep(5'd2), 1'b0, 1'b0);
                send_beat(rep(5'd3), rep(5'd3), 1'b0, 1'b0);
                send_beat(rep(5'd2), rep(5'd3), 1'b0, 1'b0);
            end
            begin
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!out_valid_a && g < 50);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_val("stall_in_ready", 32'(in_ready_a), 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_out(n + 4);
        idle(2);
        check_val("stall_count", 32'(out_cnt - n), 32'd4);
        check_val("stall_last",  32'(last_sum_a),  32'd24);

        // Saturation on the 12-bit instance, then a clean mode 0 frame.
        n = out_cnt;
        send_beat(rep(5'd31), rep(5'd31), 1'b1, 1'b0);
        send_beat(rep(5'd31), rep(5'd31), 1'b1, 1'b1);
        wait_out(n + 1);
        check_val("sat_sum_b", 32'(last_sum_b), 32'd4095);
        check_val("sat_ovf_b", 32'(last_ovf_b), 32'd1);
        check_val("sat_sum_a", 32'(last_sum_a), 32'd7688);
        check_val("sat_ovf_a", 32'(last_ovf_a), 32'd0);
        send_beat(rep(5'd1), rep(5'd1), 1'b0, 1'b0);
        wait_out(n + 2);
        check_val("post_sat_sum_b", 32'(last_sum_b), 32'd4);
        check_val("post_sat_ovf_b", 32'(last_ovf_b), 32'd0);

        // Reset mid-frame discards the partial frame.
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b1, 1'b0);
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk);
        #1;
        idle(4);
        check_val("midrst_no_out", 32'(out_valid_a), 32'd0);
        n = out_cnt;
        send_beat(vec(5'd1, 5'd2, 5'd3, 5'd4), rep(5'd1), 1'b0, 1'b0);
        wait_out(n + 1);
        check_val("midrst_sum", 32'(last_sum_a), 32'd10);
        check_val("midrst_ovf", 32'(last_ovf_a), 32'd0);

        // Bubbles between beats of a mode 1 frame.
        n = out_cnt;
        send_beat(vec(5'd5, 5'd6, 5'd7, 5'd8), vec(5'd1, 5'd2, 5'd3, 5'd4), 1'b1, 1'b0);
        idle(2);
        send_beat(vec(5'd5, 5'd6, 5'd7, 5'd8), vec(5'd1, 5'd2, 5'd3, 5'd4), 1'b1, 1'b0);
        idle(3);
        send_beat(vec(5'd5, 5'd6, 5'd7, 5'd8), vec(5'd1, 5'd2, 5'd3, 5'd4), 1'b1, 1'b1);
        wait_out(n + 1);
        check_val("bubble_sum",     32'(last_sum_a), 32'd210);
        check_val("bubble_latency", 32'(out_cyc - last_acc_cyc), 32'd3);

        // thr change while a result is held must not alter out_fire.
        thr = 16'd100;
        out_ready = 1'b0;
        n = out_cnt;
        send_beat(rep(5'd3), rep(5'd3), 1'b0, 1'b0);
        g = 0;
        while (!out_valid_a && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        thr = 16'd0;
        repeat (4) begin
            @(negedge clk);
            check_val("hold_fire",  32'(fire_a),     32'd0);
            check_val("hold_sum",   32'(out_sum_a),  32'd36);
            check_val("hold_ready", 32'(in_ready_a), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_out(n + 1);

        // Randomised traffic with random backpressure and mode changes.
        thr = 16'($urandom_range(0, 4000));
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                send_beat(VW'($urandom()), VW'($urandom()), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0));
            end
        end
        send_beat(VW'($urandom()), VW'($urandom()), 1'b1, 1'b1);
        rdy_rand = 1'b0;
        idle(1);
        out_ready = 1'b1;
        idle(12);
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);
        check_val("drain_valid", 32'(out_valid_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
